// File: rtl/des_pkg.sv
// DES key-schedule constants: permutation tables, rotation schedule, widths, FSM states.
// Tables hold 1-based DES bit indices (DES bit 1 = MSB of the vector).
package des_pkg;

   localparam int KEY_W  = 64;
   localparam int CD_W   = 56;
   localparam int RK_W   = 48;
   localparam int HALF_W = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam int PC1 [CD_W] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2 [RK_W] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // SHIFTS[k-1] is the left rotation applied to reach round k
   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
      logic [CD_W-1:0] v;
      v = '0;
      for (int j = 0; j < CD_W; j++) v[CD_W-1-j] = k[KEY_W-PC1[j]];
      return v;
   endfunction

   function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
      return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
   endfunction

   function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
      return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
   endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: selects the 48 round-key bits from the 56-bit C/D state.
module des_pc2
   import des_pkg::*;
(
   input  logic [CD_W-1:0] i_cd,
   output logic [RK_W-1:0] o_key
);

   always_comb begin
      o_key = '0;
      for (int j = 0; j < RK_W; j++) o_key[RK_W-1-j] = i_cd[CD_W-PC2[j]];
   end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule serving one round key per accepted handshake.
// Build option DES_KS_PARITY_EN adds an odd-parity check of the key bytes at start.
//
//   state | meaning
//   IDLE  | waiting for start; CD holds the last state
//   RUN   | serving round keys, key_valid high
//   FIN   | one-cycle done pulse
module des_key_schedule
   import des_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [KEY_W-1:0] key_in,
   input  logic             decrypt,
   output logic             busy,
   output logic             key_valid,
   input  logic             key_ready,
   output logic [RK_W-1:0]  round_key,
   output logic [3:0]       round_idx,
   output logic             done,
   output logic             key_err
);

   state_t            r_state, w_next;
   logic [CD_W-1:0]   r_cd;
   logic [3:0]        r_round_idx;
   logic              r_mode;
   logic              w_key_ok;
   logic              w_accept;
   logic              w_last;
   logic              w_enc_two;
   logic              w_dec_two;
   logic [CD_W-1:0]   w_pc1;
   logic [HALF_W-1:0] w_c, w_d;

`ifdef DES_KS_PARITY_EN
   logic r_key_err;

   always_comb begin
      w_key_ok = 1'b1;
      for (int b = 0; b < 8; b++) if (!(^key_in[8*b +: 8])) w_key_ok = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            r_key_err <= 1'b0;
      else if (r_state == IDLE && start)  r_key_err <= !w_key_ok;
   end

   assign key_err = r_key_err;
`else
   assign w_key_ok = 1'b1;
   assign key_err  = 1'b0;
`endif

   assign w_accept  = (r_state == RUN) && key_ready;
   assign w_last    = (r_round_idx == 4'd15);
   assign w_pc1     = pc1(key_in);
   assign w_c       = r_cd[CD_W-1:HALF_W];
   assign w_d       = r_cd[HALF_W-1:0];
   // encrypt keeps CD one round ahead, so it looks up the next round's shift
   assign w_enc_two = (SHIFTS[r_round_idx + 4'd1] == 2);
   assign w_dec_two = (SHIFTS[4'd15 - r_round_idx] == 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      busy      = 1'b0;
      key_valid = 1'b0;
      done      = 1'b0;
      case (r_state)
         IDLE: if (start && w_key_ok) w_next = RUN;
         RUN: begin
            busy      = 1'b1;
            key_valid = 1'b1;
            if (w_accept && w_last) w_next = FIN;
         end
         FIN: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cd        <= '0;
         r_round_idx <= '0;
         r_mode      <= 1'b0;
      end else if (r_state == IDLE && start && w_key_ok) begin
         r_cd        <= decrypt ? w_pc1
                                : {rotl(w_pc1[CD_W-1:HALF_W], 1'b0), rotl(w_pc1[HALF_W-1:0], 1'b0)};
         r_mode      <= decrypt;
         r_round_idx <= '0;
      end else if (w_accept && !w_last) begin
         r_round_idx <= r_round_idx + 4'd1;
         r_cd        <= r_mode ? {rotr(w_c, w_dec_two), rotr(w_d, w_dec_two)}
                               : {rotl(w_c, w_enc_two), rotl(w_d, w_enc_two)};
      end
   end

   des_pc2 u_pc2 (
      .i_cd  (r_cd),
      .o_key (round_key)
   );

   assign round_idx = r_round_idx;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule with a cumulative-shift reference model.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] key_in = '0;
   logic        decrypt = 1'b0;
   logic        busy, key_valid, done, key_err;
   logic        key_ready = 1'b0;
   logic [47:0] round_key;
   logic [3:0]  round_idx;

   int total = 0;
   int bad   = 0;

   logic [47:0] m_keys [16];
   logic [47:0] obs    [16];

   localparam int T_PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int T_PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   des_key_schedule dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_in    (key_in),
      .decrypt   (decrypt),
      .busy      (busy),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .round_key (round_key),
      .round_idx (round_idx),
      .done      (done),
      .key_err   (key_err)
   );

   always #5 clk = ~clk;

   // K_n = PC2(C0 <<< sum(s1..sn), D0 <<< sum(s1..sn)), straight from the DES definition
   task automatic compute_model(input logic [63:0] key);
      bit c0 [1:28];
      bit d0 [1:28];
      bit cd [1:56];
      int tot;
      for (int p = 1; p <= 28; p++) begin
         c0[p] = key[64 - T_PC1[p-1]];
         d0[p] = key[64 - T_PC1[p+27]];
      end
      tot = 0;
      for (int n = 1; n <= 16; n++) begin
         tot += T_SH[n-1];
         for (int p = 1; p <= 28; p++) begin
            cd[p]      = c0[((p - 1 + tot) % 28) + 1];
            cd[p + 28] = d0[((p - 1 + tot) % 28) + 1];
         end
         for (int j = 0; j < 48; j++) m_keys[n-1][47-j] = cd[T_PC2[j]];
      end
   endtask

   function automatic logic [63:0] odd_parity(input logic [63:0] k);
      logic [63:0] v;
      v = k;
      for (int b = 0; b < 8; b++) v[8*b] = ~^v[8*b+1 +: 7];
      return v;
   endfunction

   function automatic logic [63:0] rand_key();
      return odd_parity({$urandom(), $urandom()});
   endfunction

   task automatic run_schedule(input logic [63:0] key, input logic dec, input bit stall,
                               input bit inject, input logic [63:0] other);
      int cycles, got, exp_i;
      bit rdy;
      compute_model(key);
      @(negedge clk);
      key_in = key; decrypt = dec; start = 1'b1; key_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; key_in = rand_key(); decrypt = ~dec;
      total++;
      if ({busy, key_valid, key_err} !== 3'b110) begin
         bad++;
         $display("FAIL first_valid: busy/valid/err=%b required 110", {busy, key_valid, key_err});
      end
      cycles = 0; got = 0;
      while (got < 16 && cycles < 300) begin
         exp_i = dec ? 15 - got : got;
         total++;
         if (key_valid !== 1'b1 || round_idx !== got[3:0] || round_key !== m_keys[exp_i]) begin
            bad++;
            $display("FAIL round_key: valid=%b idx=%0d key=%h required idx=%0d key=%h",
                     key_valid, round_idx, round_key, got, m_keys[exp_i]);
         end
         rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         key_ready = rdy;
         if (rdy) obs[got] = round_key;
         if (inject && got == 5) begin
            start = 1'b1; key_in = other; decrypt = ~dec;
         end
         @(negedge clk);
         start = 1'b0;
         if (stall && !rdy) begin
            repeat ($urandom_range(0, 4)) begin
               total++;
               if (round_idx !== got[3:0] || round_key !== m_keys[exp_i]) begin
                  bad++;
                  $display("FAIL stall_hold: idx=%0d key=%h required idx=%0d key=%h",
                           round_idx, round_key, got, m_keys[exp_i]);
               end
               @(negedge clk);
               cycles++;
            end
         end
         cycles++;
         if (rdy) got++;
      end
      key_ready = 1'b0;
      total++;
      if ({done, busy, key_valid} !== 3'b100) begin
         bad++;
         $display("FAIL done_pulse: done/busy/valid=%b required 100", {done, busy, key_valid});
      end
      if (!stall) begin
         total++;
         if (cycles != 16) begin
            bad++;
            $display("FAIL throughput: cycles=%0d required 16", cycles);
         end
      end
      @(negedge clk);
      total++;
      if ({done, busy} !== 2'b00) begin
         bad++;
         $display("FAIL done_width: done/busy=%b required 00", {done, busy});
      end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({busy, key_valid, done, key_err, round_idx, round_key} !== 56'd0) begin
         bad++;
         $display("FAIL reset_state: busy=%b valid=%b done=%b err=%b idx=%0d key=%h required all 0",
                  busy, key_valid, done, key_err, round_idx, round_key);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_encrypt_vector();
      logic [47:0] e [3];
      run_schedule(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, 64'h0);
      e[0] = 48'h1B02EFFC7072; e[1] = 48'h79AED9DBC9E5; e[2] = 48'hCB3D8B0E17F5;
      total++;
      if (obs[0] !== e[0] || obs[1] !== e[1] || obs[15] !== e[2]) begin
         bad++;
         $display("FAIL enc_vector: k1=%h k2=%h k16=%h required %h %h %h",
                  obs[0], obs[1], obs[15], e[0], e[1], e[2]);
      end
   endtask

   task automatic test_decrypt_vector();
      logic [47:0] enc [16];
      for (int i = 0; i < 16; i++) enc[i] = obs[i];
      run_schedule(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0, 64'h0);
      total++;
      if (obs[0] !== 48'hCB3D8B0E17F5 || obs[15] !== 48'h1B02EFFC7072) begin
         bad++;
         $display("FAIL dec_vector: first=%h last=%h required CB3D8B0E17F5 1B02EFFC7072",
                  obs[0], obs[15]);
      end
      for (int i = 0; i < 16; i++) begin
         total++;
         if (obs[i] !== enc[15-i]) begin
            bad++;
            $display("FAIL dec_reverse: idx=%0d got=%h required %h", i, obs[i], enc[15-i]);
         end
      end
   endtask

   task automatic test_backpressure();
      for (int n = 0; n < 6; n++) run_schedule(rand_key(), n[0], 1'b1, 1'b0, 64'h0);
   endtask

   task automatic test_start_while_busy();
      run_schedule(rand_key(), 1'b0, 1'b0, 1'b1, rand_key());
      run_schedule(rand_key(), 1'b1, 1'b1, 1'b1, rand_key());
   endtask

   task automatic test_reset_mid();
      int budget;
      logic [63:0] zk;
      @(negedge clk);
      key_in = rand_key(); decrypt = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; key_ready = 1'b1;
      budget = 0;
      while (round_idx !== 4'd7 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      key_ready = 1'b0;
      total++;
      if (round_idx !== 4'd7) begin
         bad++;
         $display("FAIL reach_round7: idx=%0d required 7", round_idx);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({busy, key_valid, done, round_idx, round_key} !== 55'd0) begin
         bad++;
         $display("FAIL reset_mid: busy=%b valid=%b done=%b idx=%0d key=%h required all 0",
                  busy, key_valid, done, round_idx, round_key);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         total++;
         if ({done, key_valid} !== 2'b00) begin
            bad++;
            $display("FAIL no_done_after_rst: done/valid=%b required 00", {done, key_valid});
         end
      end
`ifdef DES_KS_PARITY_EN
      zk = 64'h0101010101010101;
`else
      zk = 64'h0;
`endif
      run_schedule(zk, 1'b0, 1'b0, 1'b0, 64'h0);
      for (int i = 0; i < 16; i++) begin
         total++;
         if (obs[i] !== 48'h0) begin
            bad++;
            $display("FAIL zero_key: idx=%0d got=%h required 0", i, obs[i]);
         end
      end
   endtask

`ifdef DES_KS_PARITY_EN
   task automatic test_parity();
      @(negedge clk);
      key_in = 64'h133457799BBCDFF0; decrypt = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         total++;
         if ({key_err, key_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL parity_err: err/valid/busy=%b required 100", {key_err, key_valid, busy});
         end
         @(negedge clk);
      end
      run_schedule(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, 64'h0);
      total++;
      if (obs[0] !== 48'h1B02EFFC7072 || key_err !== 1'b0) begin
         bad++;
         $display("FAIL parity_recover: k1=%h err=%b required 1B02EFFC7072 0", obs[0], key_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_encrypt_vector();
      test_decrypt_vector();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid();
`ifdef DES_KS_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES key schedule that produces the 16 48-bit round keys consumed on the r_key input of the f-block, one key per round. It latches a 64-bit key on a start pulse and applies PC-1. It then steps the 56-bit C/D state through the per-round rotations and presents PC-2 of the current state under a valid/ready handshake. Encrypt order (K1..K16) and decrypt order (K16..K1) are both supported without precomputing keys.

Parameters:
none (DES widths are fixed constants in des_pkg)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a schedule; sampled only in IDLE
key_in  input  64  DES key; key_in[63] = DES bit 1, parity bits at DES bits 8,16,...,64
decrypt  input  1  sampled with start: 0 = K1..K16 order, 1 = K16..K1 order
busy  output  1  high from the cycle after start until the cycle done pulses
key_valid  output  1  round_key and round_idx are valid
key_ready  input  1  consumer accepts the current round key
round_key  output  48  current round key; round_key[47] = DES bit 1 (same order as f-block r_key)
round_idx  output  4  round number 0..15 of the round being served (0 = first round used)
done  output  1  one-cycle pulse after the 16th key is accepted
key_err  output  1  parity error flag (see Optional Feature)

Behaviour:
- Reset (async, immediate): state=IDLE; busy, key_valid, done, key_err = 0; round_idx = 0; CD register = 0, so round_key = PC2(0) = 0.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1 at edge t: CD <= PC1(key_in); mode <= decrypt; round_idx <= 0; state -> RUN.
  - At t+1: busy=1, key_valid=1, round_key = first key.
  - start in any other state is ignored.
- First key: encrypt presents PC2(rotl1(C0),rotl1(D0)) = K1. Decrypt presents PC2(C0,D0) = K16, because the total left shift is 28.
- Shift table s(1..16) = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. C and D (28 bits each) rotate independently.
- Encrypt: CD is held pre-rotated, so the register holds C1D1 while round 0 is served.
  - On acceptance of round i (0-based): C,D rotate left by s(i+2).
- Decrypt: on acceptance of round i: C,D rotate right by s(16-i).
- round_key = PC2(CD) combinationally from the register. It is stable while key_valid & !key_ready.
- Handshake: acceptance = key_valid & key_ready.
  - On acceptance with round_idx<15: round_idx += 1, CD advances, key_valid stays 1. The next key is visible the following cycle, so one key per cycle is possible.
  - On acceptance with round_idx==15: key_valid <= 0, state -> FIN.
- FIN: done=1 for exactly one cycle; busy drops the same cycle; state -> IDLE. start is accepted again from the next cycle.
- key_ready while key_valid=0 has no effect. key_in and decrypt are ignored outside the start edge.
- Reset asserted mid-schedule aborts it. No done is produced; the next schedule needs a fresh start.

Optional Feature:
Macro: DES_KS_PARITY_EN
- Defined: at the start edge, each key byte is checked for odd parity.
  - On any failing byte: key_err <= 1, state stays IDLE, no keys are produced.
  - key_err clears on the next start with a good key, or on rst.
- Undefined: parity bits are ignored, key_err is tied 0, and the checker logic is absent.

Decomposition:
- des_pkg holds:
  - PC1 (56 entries) and PC2 (48 entries) tables as 1-based DES bit indices.
  - Shift table s(1..16).
  - Width constants: 64, 56, 48, 28.
  - State enum IDLE/RUN/FIN.
- One natural sub-module: des_pc2, a combinational 56->48 selection, reused by the round_key output path.
- PC-1 and the rotators stay inline.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, key_ready=1 -> key_valid at start+1:
  - round_idx 0: round_key = 0x1B02EFFC7072
  - round_idx 1: round_key = 0x79AED9DBC9E5
  - round_idx 15: round_key = 0xCB3D8B0E17F5
  - done one cycle after the 16th acceptance; 16 keys in 16 consecutive cycles.
- Decrypt, same key -> round_idx 0 = 0xCB3D8B0E17F5, round_idx 1 = K15, round_idx 15 = 0x1B02EFFC7072. The sequence is the exact reverse of the encrypt run.
- Backpressure: key_ready randomly 0 for 1-5 cycles -> round_key/round_idx are held while stalled; the same 16-key sequence results; no key is skipped or duplicated.
- start pulsed while busy with a different key -> ignored; the sequence continues unchanged; busy/done timing is unaffected.
- rst asserted at round_idx 7 -> outputs zero immediately, no done. A new start with key 0x0000000000000000 yields all-zero round keys.
- With DES_KS_PARITY_EN: key 0x133457799BBCDFF0 (last byte even parity) -> key_err=1, key_valid stays 0. A following start with 0x133457799BBCDFF1 clears key_err and runs normally.
